// File: rtl/projectile_pkg.sv
// Shared types and constants for the projectile engine.
package projectile_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } state_e;

    // Launch offset from the paddle top-left to the shot top-left.
    localparam int LAUNCH_DX = 50;
    localparam int LAUNCH_DY = 20;

    // One bit wider than a screen coordinate so box sums never wrap.
    typedef logic [16:0] coord_t;

    function automatic coord_t to_coord(input logic [15:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/projectile_tick_gen.sv
// Free-running movement tick: one-cycle strobe every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 350000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wrap at terminal count, otherwise count up.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/projectile.sv
// Player projectile engine: launch from the paddle, step right on each
// movement tick, retire on enemy overlap (hit pulse) or at the right edge.
// Optional lockout after retire: define PROJECTILE_COOLDOWN_EN.
//
// state    | meaning
// IDLE     | no shot; fire launches one
// FLIGHT   | shot moving, hit-tested every clock
// COOLDOWN | shot retired, waiting COOLDOWN_TICKS ticks
module projectile
    import projectile_pkg::*;
#(
    parameter int TICK_DIV       = 350000,
    parameter int STEP           = 4,
    parameter int X_LIMIT        = 700,
    parameter int BOX            = 50,
    parameter int PROJ_W         = 8,
    parameter int COOLDOWN_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fire_i,
    input  logic [15:0] x_player_i,
    input  logic [15:0] y_player_i,
    input  logic [15:0] x_enemy_i,
    input  logic [15:0] y_enemy_i,
    output logic [15:0] x_proj_o,
    output logic [15:0] y_proj_o,
    output logic        proj_on_o,
    output logic        hit_o,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        on_q, on_d, hit_q, hit_d, busy_q, busy_d;
    logic        tick;
    logic        overlap, at_limit;
    coord_t      xp, yp, xe, ye;

`ifdef PROJECTILE_COOLDOWN_EN
    localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_TICKS - 1);
    localparam state_e RETIRE = COOLDOWN;
    logic [CD_W-1:0] cd_q, cd_d;
`else
    localparam state_e RETIRE = IDLE;
    logic unused_cooldown_ticks;
    assign unused_cooldown_ticks = ^COOLDOWN_TICKS;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign xp = to_coord(x_q);
    assign yp = to_coord(y_q);
    assign xe = to_coord(x_enemy_i);
    assign ye = to_coord(y_enemy_i);

    assign overlap = (xp + coord_t'(PROJ_W) > xe) && (xp < xe + coord_t'(BOX)) &&
                     (yp + coord_t'(PROJ_W) > ye) && (yp < ye + coord_t'(BOX));
    assign at_limit = (xp + coord_t'(STEP) >= coord_t'(X_LIMIT));

    // Next-state and output decode; a hit pre-empts any move or miss.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        on_d    = on_q;
        hit_d   = 1'b0;
`ifdef PROJECTILE_COOLDOWN_EN
        cd_d    = cd_q;
`endif
        case (state_q)
            IDLE: begin
                if (fire_i) begin
                    x_d     = x_player_i + 16'(LAUNCH_DX);
                    y_d     = y_player_i + 16'(LAUNCH_DY);
                    on_d    = 1'b1;
                    state_d = FLIGHT;
                end
            end
            FLIGHT: begin
                if (overlap) begin
                    hit_d   = 1'b1;
                    on_d    = 1'b0;
                    state_d = RETIRE;
`ifdef PROJECTILE_COOLDOWN_EN
                    cd_d    = CD_LOAD;
`endif
                end else if (tick) begin
                    if (at_limit) begin
                        on_d    = 1'b0;
                        state_d = RETIRE;
`ifdef PROJECTILE_COOLDOWN_EN
                        cd_d    = CD_LOAD;
`endif
                    end else begin
                        x_d = x_q + 16'(STEP);
                    end
                end
            end
`ifdef PROJECTILE_COOLDOWN_EN
            COOLDOWN: begin
                if (tick) begin
                    if (cd_q == '0) state_d = IDLE;
                    else            cd_d    = cd_q - CD_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            on_q    <= 1'b0;
            hit_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            on_q    <= on_d;
            hit_q   <= hit_d;
            busy_q  <= busy_d;
        end
    end

`ifdef PROJECTILE_COOLDOWN_EN
    // Cooldown tick counter, loaded on retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cd_q <= '0;
        else        cd_q <= cd_d;
    end
`endif

    assign x_proj_o  = x_q;
    assign y_proj_o  = y_q;
    assign proj_on_o = on_q;
    assign hit_o     = hit_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_projectile.sv
// Bench for projectile: directed scenarios plus randomized shots, every
// cycle compared against a cycle-level behavioural model of the engine.
module tb_projectile;

    localparam int TD  = 4;
    localparam int ST  = 4;
    localparam int XL  = 700;
    localparam int BX  = 50;
    localparam int PW  = 8;
    localparam int CDT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fire = 1'b0;
    logic [15:0] xpl = '0, ypl = '0, xen = '0, yen = '0;
    logic [15:0] x_proj, y_proj;
    logic        proj_on, hit, busy;

    projectile #(
        .TICK_DIV(TD), .STEP(ST), .X_LIMIT(XL), .BOX(BX), .PROJ_W(PW), .COOLDOWN_TICKS(CDT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fire_i     (fire),
        .x_player_i (xpl),
        .y_player_i (ypl),
        .x_enemy_i  (xen),
        .y_enemy_i  (yen),
        .x_proj_o   (x_proj),
        .y_proj_o   (y_proj),
        .proj_on_o  (proj_on),
        .hit_o      (hit),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, 1 shot in flight, 2 locked out.
    int m_mode, m_x, m_y, m_left, ecount;
    bit m_on, m_hit;

    // Observation bookkeeping.
    int  cycle = 0, hits_seen = 0, launches = 0, hit_x = -1, x_at_retire = -1;
    int  retire_cyc = 0, idle_cyc = 0;
    bit  prev_on = 0, prev_busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_x = 0; m_y = 0; m_left = 0; m_on = 0; m_hit = 0; ecount = 0;
    endtask

    task automatic retire();
`ifdef PROJECTILE_COOLDOWN_EN
        m_mode = 2; m_left = CDT;
`else
        m_mode = 0;
`endif
        m_on = 0;
    endtask

    // One clock edge of the engine's rules, using pre-edge inputs.
    task automatic model_edge();
        bit t, ov;
        int xe, ye;
        t = (ecount % TD) == TD - 1;
        ecount++;
        m_hit = 0;
        xe = int'(xen);
        ye = int'(yen);
        if (m_mode == 0) begin
            if (fire) begin
                m_x = (int'(xpl) + 50) % 65536;
                m_y = (int'(ypl) + 20) % 65536;
                m_on = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            ov = (m_x + PW > xe) && (m_x < xe + BX) && (m_y + PW > ye) && (m_y < ye + BX);
            if (ov) begin
                m_hit = 1; retire();
            end else if (t) begin
                if (m_x + ST >= XL) retire();
                else m_x = m_x + ST;
            end
        end else if (t) begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
        #1;
        cycle++;
        chk("x_proj", 32'(x_proj), 32'(m_x));
        chk("y_proj", 32'(y_proj), 32'(m_y));
        chk("proj_on", 32'(proj_on), 32'(m_on));
        chk("hit", 32'(hit), 32'(m_hit));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        if (hit === 1'b1) begin hits_seen++; hit_x = int'(x_proj); end
        if (prev_on && proj_on === 1'b0) begin retire_cyc = cycle; x_at_retire = int'(x_proj); end
        if (!prev_on && proj_on === 1'b1) launches++;
        if (prev_busy && busy === 1'b0) idle_cyc = cycle;
        prev_on = (proj_on === 1'b1);
        prev_busy = (busy === 1'b1);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int k = 0;
        while (busy === 1'b1 && k < budget) begin cyc(); k++; end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic shoot();
        fire = 1'b1; cyc(); fire = 1'b0;
    endtask

    initial begin
        int k;
        int xb;
        model_reset();
        repeat (3) cyc();
        chk("reset_x", 32'(x_proj), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Miss: enemy parked out of the shot's row.
        xpl = 16'd100; ypl = 16'd440; xen = 16'd600; yen = 16'd100;
        hits_seen = 0;
        shoot();
        chk("miss_launch_x", 32'(x_proj), 32'd150);
        chk("miss_launch_y", 32'(y_proj), 32'd460);
        run_until_idle("miss_wait", 2000);
        chk("miss_last_x", 32'(x_at_retire), 32'd698);
        chk("miss_no_hit", 32'(hits_seen), 32'd0);
`ifdef PROJECTILE_COOLDOWN_EN
        chk("miss_cooldown_len", 32'(idle_cyc - retire_cyc), 32'(CDT * TD));
`else
        chk("miss_cooldown_len", 32'(idle_cyc - retire_cyc), 32'd0);
`endif

        // Hit: enemy straight ahead.
        xen = 16'd170; yen = 16'd440; hits_seen = 0;
        shoot();
        run_until_idle("hit_wait", 500);
        chk("hit_count", 32'(hits_seen), 32'd1);
        chk("hit_x", 32'(hit_x), 32'd166);
        chk("hit_proj_off", 32'(x_at_retire), 32'd166);

        // Same-cycle hit and tick: move the enemy onto the shot just before a tick.
        xen = 16'd600; yen = 16'd100;
        shoot();
        repeat (9) cyc();
        k = 0;
        while ((ecount % TD) != TD - 1 && k < TD) begin cyc(); k++; end
        xb = int'(x_proj);
        xen = x_proj; yen = 16'd440;
        cyc();
        chk("tick_hit", 32'(hit), 32'd1);
        chk("tick_hit_x", 32'(x_proj), 32'(xb));
        run_until_idle("tick_hit_wait", 500);

        // Fire held through flight and lockout is not queued.
        xen = 16'd170; yen = 16'd440; launches = 0;
        fire = 1'b1;
        k = 0;
        while (launches < 2 && k < 300) begin cyc(); k++; end
        fire = 1'b0;
        chk("held_fire_relaunch", 32'(launches), 32'd2);
        run_until_idle("held_fire_wait", 500);

        // Reset mid-flight.
        xpl = 16'd98; xen = 16'd600; yen = 16'd100; hits_seen = 0;
        shoot();
        k = 0;
        while (x_proj !== 16'd300 && k < 800) begin cyc(); k++; end
        chk("rst_reach_300", 32'(x_proj), 32'd300);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst_async_x", 32'(x_proj), 32'd0);
        chk("rst_async_on", 32'(proj_on), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (2) cyc();
        @(negedge clk); rst_n = 1'b1;
        xpl = 16'd100;
        shoot();
        chk("rst_relaunch_x", 32'(x_proj), 32'd150);
        chk("rst_no_hit", 32'(hits_seen), 32'd0);
        run_until_idle("rst_relaunch_wait", 2000);

        // Y edge: 468 > 488 is false, then 468 > 467 is true.
        xen = 16'd170; yen = 16'd488; hits_seen = 0;
        shoot();
        run_until_idle("yedge_miss_wait", 2000);
        chk("yedge_no_hit", 32'(hits_seen), 32'd0);
        yen = 16'd467;
        shoot();
        run_until_idle("yedge_hit_wait", 500);
        chk("yedge_hit", 32'(hits_seen), 32'd1);

        // Randomized shots, including wrap-sized enemy coordinates.
        for (int s = 0; s < 25; s++) begin
            xpl = 16'($urandom_range(0, 800));
            ypl = 16'($urandom_range(0, 500));
            xen = 16'(int'(xpl) + 40 + int'($urandom_range(0, 400)));
            yen = 16'(int'(ypl) + int'($urandom_range(0, 90)) - 30);
            if (s % 5 == 4) xen = 16'hFFF0 + 16'($urandom_range(0, 15));
            fire = 1'b1;
            repeat ($urandom_range(1, 3)) cyc();
            fire = 1'b0;
            k = 0;
            while (busy === 1'b1 && k < 1500) begin
                fire = (m_mode != 0) && ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 19) == 0) xen = 16'(int'(xen) + int'($urandom_range(0, 40)) - 20);
                cyc();
                k++;
            end
            fire = 1'b0;
            chk("rand_wait", 32'(k < 1500), 32'd1);
            repeat (2) cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
